// File: rtl/sd_block_streamer_pkg.sv
// Shared types and helpers for the SD multi-block streamer.
// Holds the FSM encoding, error codes and the byte-wise CRC16-CCITT step.
package sd_block_streamer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_INIT,
        ST_WAIT_INIT,
        ST_READ,
        ST_CAPTURE,
        ST_CHECK,
        ST_STREAM
    } state_e;

    localparam logic [1:0] ERR_NONE         = 2'd0;
    localparam logic [1:0] ERR_INIT_TIMEOUT = 2'd1;
    localparam logic [1:0] ERR_RETRY        = 2'd2;

    localparam logic [15:0] CRC_POLY = 16'h1021;
    localparam logic [15:0] CRC_INIT = 16'h0000;

    function automatic logic [15:0] crc16_update(
        input logic [15:0] crc,
        input logic [7:0]  data
    );
        logic [15:0] c;
        c = crc ^ {data, 8'h00};
        for (int i = 0; i < 8; i++) begin
            if (c[15]) c = {c[14:0], 1'b0} ^ CRC_POLY;
            else       c = {c[14:0], 1'b0};
        end
        return c;
    endfunction

endpackage

// File: rtl/crc16_ccitt_byte.sv
// Registered CRC16-CCITT accumulator, one byte per enabled cycle.
// Clear has priority over enable and restores the initial value.
module crc16_ccitt_byte
    import sd_block_streamer_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        clear,
    input  logic        en,
    input  logic [7:0]  data,
    output logic [15:0] crc
);

    logic [15:0] crc_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            crc_q <= CRC_INIT;
        end else if (clear) begin
            crc_q <= CRC_INIT;
        end else if (en) begin
            crc_q <= crc16_update(crc_q, data);
        end
    end

    assign crc = crc_q;

endmodule

// File: rtl/sd_block_streamer.sv
// Reads consecutive SD blocks, verifies CRC16 with retries, and streams
// only verified bytes through a valid/ready interface.
module sd_block_streamer
    import sd_block_streamer_pkg::*;
#(
    parameter int BLOCK_BYTES  = 512,
    parameter int ADDR_WIDTH   = 32,
    parameter int COUNT_WIDTH  = 8,
    parameter int MAX_RETRY    = 3,
    parameter int ADDR_MODE    = 0,
    parameter int INIT_TIMEOUT = 1_000_000
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   start,
    input  logic [ADDR_WIDTH-1:0]  block_addr,
    input  logic [COUNT_WIDTH-1:0] block_count,
    output logic                   init_start,
    input  logic                   init_ready,
    output logic                   rd_start,
    output logic [ADDR_WIDTH-1:0]  rd_addr,
    input  logic                   rd_busy,
    input  logic                   rd_valid,
    input  logic [7:0]             rd_data,
    output logic [7:0]             out_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   busy,
    output logic                   done,
    output logic [1:0]             error,
    output logic [7:0]             retry_total
);

    localparam int BW = $clog2(BLOCK_BYTES + 3);
    localparam int AW = $clog2(BLOCK_BYTES);
    localparam int RW = $clog2(MAX_RETRY + 2);
    localparam int TW = $clog2(INIT_TIMEOUT + 1);
    localparam logic [ADDR_WIDTH-1:0] ADDR_STEP =
        (ADDR_MODE != 0) ? ADDR_WIDTH'(BLOCK_BYTES) : ADDR_WIDTH'(1);

    state_e                 state_q, state_d;
    logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
    logic [COUNT_WIDTH-1:0] remain_q, remain_d;
    logic [RW-1:0]          retry_q, retry_d;
    logic [7:0]             rtot_q, rtot_d;
    logic [1:0]             err_q, err_d;
    logic                   done_q, done_d;
    logic [TW-1:0]          tmo_q, tmo_d;
    logic [BW-1:0]          cnt_q, cnt_d;
    logic                   bad_q, bad_d;
    logic [15:0]            rxcrc_q, rxcrc_d;
    logic                   rdb_q;
    logic [BW-1:0]          rptr_q, rptr_d;
    logic [BW-1:0]          sent_q, sent_d;
    logic                   s1v_q, s1v_d;
    logic                   ov_q, ov_d;
    logic [7:0]             od_q, od_d;

    logic [7:0]  ram [BLOCK_BYTES];
    logic [7:0]  ram_rdata_q;
    logic        crc_clr, crc_en, wr_en, issue, s2_load, hs;
    logic [15:0] crc_calc;

    crc16_ccitt_byte u_crc (
        .clock (clock),
        .reset (reset),
        .clear (crc_clr),
        .en    (crc_en),
        .data  (rd_data),
        .crc   (crc_calc)
    );

    // Block buffer: one write port from capture, one registered read port.
    always_ff @(posedge clock) begin
        if (wr_en) ram[cnt_q[AW-1:0]] <= rd_data;
        if (issue) ram_rdata_q <= ram[rptr_q[AW-1:0]];
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            addr_q   <= '0;
            remain_q <= '0;
            retry_q  <= '0;
            rtot_q   <= '0;
            err_q    <= ERR_NONE;
            done_q   <= 1'b0;
            tmo_q    <= '0;
            cnt_q    <= '0;
            bad_q    <= 1'b0;
            rxcrc_q  <= '0;
            rdb_q    <= 1'b0;
            rptr_q   <= '0;
            sent_q   <= '0;
            s1v_q    <= 1'b0;
            ov_q     <= 1'b0;
            od_q     <= '0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            remain_q <= remain_d;
            retry_q  <= retry_d;
            rtot_q   <= rtot_d;
            err_q    <= err_d;
            done_q   <= done_d;
            tmo_q    <= tmo_d;
            cnt_q    <= cnt_d;
            bad_q    <= bad_d;
            rxcrc_q  <= rxcrc_d;
            rdb_q    <= rd_busy;
            rptr_q   <= rptr_d;
            sent_q   <= sent_d;
            s1v_q    <= s1v_d;
            ov_q     <= ov_d;
            od_q     <= od_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        remain_d = remain_q;
        retry_d  = retry_q;
        rtot_d   = rtot_q;
        err_d    = err_q;
        done_d   = 1'b0;
        tmo_d    = tmo_q;
        cnt_d    = cnt_q;
        bad_d    = bad_q;
        rxcrc_d  = rxcrc_q;
        rptr_d   = rptr_q;
        sent_d   = sent_q;
        s1v_d    = s1v_q;
        ov_d     = ov_q;
        od_d     = od_q;
        crc_clr  = 1'b0;
        crc_en   = 1'b0;
        wr_en    = 1'b0;
        issue    = 1'b0;
        s2_load  = 1'b0;
        hs       = ov_q & out_ready;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    addr_d   = block_addr;
                    remain_d = block_count;
                    retry_d  = '0;
                    rtot_d   = '0;
                    err_d    = ERR_NONE;
                    if (block_count == '0) done_d = 1'b1;
                    else                   state_d = ST_INIT;
                end
            end
            ST_INIT: begin
                tmo_d   = TW'(1);
                state_d = ST_WAIT_INIT;
            end
            ST_WAIT_INIT: begin
                if (init_ready) begin
                    state_d = ST_READ;
                end else if (tmo_q >= TW'(INIT_TIMEOUT)) begin
                    err_d   = ERR_INIT_TIMEOUT;
                    state_d = ST_IDLE;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            ST_READ: begin
                cnt_d   = '0;
                bad_d   = 1'b0;
                rxcrc_d = '0;
                crc_clr = 1'b1;
                state_d = ST_CAPTURE;
            end
            ST_CAPTURE: begin
                // Count saturates at the full frame size; overflow sets bad.
                if (rd_valid) begin
                    if (cnt_q < BW'(BLOCK_BYTES)) begin
                        wr_en  = 1'b1;
                        crc_en = 1'b1;
                    end else if (cnt_q == BW'(BLOCK_BYTES)) begin
                        rxcrc_d[15:8] = rd_data;
                    end else if (cnt_q == BW'(BLOCK_BYTES + 1)) begin
                        rxcrc_d[7:0] = rd_data;
                    end else begin
                        bad_d = 1'b1;
                    end
                    if (cnt_q != BW'(BLOCK_BYTES + 2)) cnt_d = cnt_q + 1'b1;
                end
                if (rdb_q && !rd_busy) state_d = ST_CHECK;
            end
            ST_CHECK: begin
                if (cnt_q == BW'(BLOCK_BYTES + 2) && !bad_q &&
                    crc_calc == rxcrc_q) begin
                    rptr_d  = '0;
                    sent_d  = '0;
                    s1v_d   = 1'b0;
                    state_d = ST_STREAM;
                end else if (retry_q < RW'(MAX_RETRY)) begin
                    retry_d = retry_q + 1'b1;
                    if (rtot_q != 8'hFF) rtot_d = rtot_q + 1'b1;
                    state_d = ST_READ;
                end else begin
                    err_d   = ERR_RETRY;
                    state_d = ST_IDLE;
                end
            end
            ST_STREAM: begin
                // RAM data stage feeds the output register; a read is only
                // issued when the RAM data stage is free this cycle.
                s2_load = s1v_q & (~ov_q | out_ready);
                issue   = (rptr_q < BW'(BLOCK_BYTES)) & (~s1v_q | s2_load);
                if (issue) rptr_d = rptr_q + 1'b1;
                s1v_d = issue | (s1v_q & ~s2_load);
                if (s2_load) begin
                    ov_d = 1'b1;
                    od_d = ram_rdata_q;
                end else if (hs) begin
                    ov_d = 1'b0;
                end
                if (hs) begin
                    sent_d = sent_q + 1'b1;
                    if (sent_q == BW'(BLOCK_BYTES - 1)) begin
                        addr_d   = addr_q + ADDR_STEP;
                        remain_d = remain_q - 1'b1;
                        retry_d  = '0;
                        if (remain_q == COUNT_WIDTH'(1)) begin
                            done_d  = 1'b1;
                            state_d = ST_IDLE;
                        end else begin
                            state_d = ST_READ;
                        end
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign init_start  = (state_q == ST_INIT);
    assign rd_start    = (state_q == ST_READ);
    assign rd_addr     = addr_q;
    assign busy        = (state_q != ST_IDLE);
    assign done        = done_q;
    assign error       = err_q;
    assign retry_total = rtot_q;
    assign out_valid   = ov_q;
    assign out_data    = od_q;

endmodule

// File: tb/tb_sd_block_streamer.sv
// Self-checking bench: card/reader models plus a byte-stream scoreboard.
// Expected addresses, bytes and outcomes come from a block-level model.
module tb_sd_block_streamer;

    localparam int BB  = 512;
    localparam int MR  = 3;
    localparam int TMO = 100;

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic [31:0] block_addr;
    logic [7:0]  block_count;
    logic        init_start;
    logic        init_ready;
    logic        rd_start;
    logic [31:0] rd_addr;
    logic        rd_busy;
    logic        rd_valid;
    logic [7:0]  rd_data;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready;
    logic        busy;
    logic        done;
    logic [1:0]  error;
    logic [7:0]  retry_total;

    sd_block_streamer #(
        .BLOCK_BYTES  (BB),
        .ADDR_WIDTH   (32),
        .COUNT_WIDTH  (8),
        .MAX_RETRY    (MR),
        .ADDR_MODE    (1),
        .INIT_TIMEOUT (TMO)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .start       (start),
        .block_addr  (block_addr),
        .block_count (block_count),
        .init_start  (init_start),
        .init_ready  (init_ready),
        .rd_start    (rd_start),
        .rd_addr     (rd_addr),
        .rd_busy     (rd_busy),
        .rd_valid    (rd_valid),
        .rd_data     (rd_data),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .busy        (busy),
        .done        (done),
        .error       (error),
        .retry_total (retry_total)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0]  mem [4][BB];
    int          fails [4];
    logic [31:0] base;
    int          blk_idx, read_idx;
    int          rd_cnt, init_cnt, done_cnt, out_cnt;
    bit          init_ok;
    int          init_delay;
    int          gap_pct;
    int          ready_pct = 100;
    int          bad_kind;
    bit          abort;
    logic [7:0]  exp_q [$];
    int          cyc = 0;
    int          last_hs = -10;
    int          init_cyc, idle_cyc;
    bit          prev_stall;
    logic [7:0]  prev_data;
    bit          expect_bytes;

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    // Bit-serial CRC16-CCITT over a stored block.
    function automatic logic [15:0] ref_crc(input int blk);
        logic [15:0] c;
        logic        fb;
        c = 16'h0000;
        for (int i = 0; i < BB; i++) begin
            for (int b = 7; b >= 0; b--) begin
                fb = c[15] ^ mem[blk][i][b];
                c  = {c[14:0], 1'b0};
                if (fb) c = c ^ 16'h1021;
            end
        end
        return c;
    endfunction

    always @(posedge clock) cyc <= cyc + 1;

    always @(posedge clock) begin
        #1;
        out_ready = ($urandom_range(0, 99) < ready_pct);
    end

    // Card initializer model.
    initial begin
        init_ready = 1'b0;
        forever begin
            @(negedge clock);
            if (init_start === 1'b1) begin
                init_cnt++;
                init_cyc = cyc;
                if (init_ok) begin
                    repeat (init_delay) @(posedge clock);
                    #1 init_ready = 1'b1;
                end
            end
        end
    end

    // Block reader model: scripted good/bad frames per block.
    initial begin
        logic [7:0]  bytes [$];
        logic [15:0] c;
        logic [31:0] ea;
        int          cur, k, idx;
        bit          bad;
        rd_busy  = 1'b0;
        rd_valid = 1'b0;
        rd_data  = 8'h00;
        forever begin
            @(negedge clock);
            if (rd_start === 1'b1) begin
                rd_cnt++;
                cur = blk_idx;
                ea  = base + 32'(cur * BB);
                check("rd_addr", rd_addr, ea);
                if (cur > 3) cur = 3;
                bad = (read_idx < fails[cur]);
                if (bad) read_idx++;
                else begin
                    blk_idx++;
                    read_idx = 0;
                end
                bytes = {};
                for (int i = 0; i < BB; i++) bytes.push_back(mem[cur][i]);
                c = ref_crc(cur);
                k = 0;
                if (bad) begin
                    k = (bad_kind < 0) ? int'($urandom_range(0, 3)) : bad_kind;
                    if (k == 0) c = c ^ (16'h0001 << $urandom_range(0, 15));
                    if (k == 2) bytes.delete(BB - 1);
                    if (k == 3) begin
                        idx = int'($urandom_range(0, BB - 1));
                        bytes[idx] = bytes[idx] ^ (8'h01 << $urandom_range(0, 7));
                    end
                    if (k == 4) c = 16'h0000;
                end
                bytes.push_back(c[15:8]);
                bytes.push_back(c[7:0]);
                if (bad && k == 1) bytes.push_back(8'($urandom));
                @(posedge clock);
                #1 rd_busy = 1'b1;
                foreach (bytes[i]) begin
                    if (abort) break;
                    while (gap_pct > 0 && !abort &&
                           $urandom_range(0, 99) < gap_pct) begin
                        rd_valid = 1'b0;
                        @(posedge clock);
                        #1;
                    end
                    rd_valid = 1'b1;
                    rd_data  = bytes[i];
                    @(posedge clock);
                    #1;
                end
                if (!abort) check("rd_addr_stable", rd_addr, ea);
                rd_valid = 1'b0;
                rd_busy  = 1'b0;
            end
        end
    end

    // Compare process: output stream vs expected queue, hold rules, done.
    always @(negedge clock) begin
        if (reset === 1'b0) begin
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL out_unexpected: got byte %0h, required no out_valid",
                             out_data);
                end else begin
                    check("out_data", out_data, exp_q[0]);
                    if (out_ready) begin
                        void'(exp_q.pop_front());
                        out_cnt++;
                        last_hs = cyc;
                    end
                end
            end
            if (prev_stall) begin
                check("hold_valid", out_valid, 1);
                check("hold_data", out_data, prev_data);
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            if (done) begin
                done_cnt++;
                check("busy_at_done", busy, 0);
                if (expect_bytes) check("done_latency", cyc, last_hs + 1);
            end
        end else begin
            prev_stall = 1'b0;
        end
    end

    task automatic pulse_start(input logic [31:0] a, input int cnt);
        @(posedge clock);
        #1;
        start       = 1'b1;
        block_addr  = a;
        block_count = 8'(cnt);
        @(posedge clock);
        #1 start = 1'b0;
    endtask

    task automatic setup(input logic [31:0] a, input int cnt);
        base     = a;
        blk_idx  = 0;
        read_idx = 0;
        rd_cnt   = 0;
        init_cnt = 0;
        done_cnt = 0;
        out_cnt  = 0;
        init_ready = 1'b0;
        exp_q    = {};
        if (cnt < 0) $display("setup: negative count");
    endtask

    task automatic run(input logic [31:0] a, input int cnt, input int restart_k);
        int e_rd, e_rt, e_init, e_done, e_err, e_bytes;
        bit failed, gone;
        setup(a, cnt);
        e_rd = 0; e_rt = 0; e_err = 0; failed = 1'b0; gone = 1'b0;
        if (cnt == 0) begin
            e_init = 0;
            e_done = 1;
        end else if (!init_ok) begin
            e_init = 1;
            e_done = 0;
            e_err  = 1;
        end else begin
            e_init = 1;
            for (int b = 0; b < cnt && !failed; b++) begin
                if (fails[b] > MR) begin
                    e_rd  += MR + 1;
                    e_rt  += MR;
                    e_err  = 2;
                    failed = 1'b1;
                end else begin
                    e_rd += fails[b] + 1;
                    e_rt += fails[b];
                    for (int i = 0; i < BB; i++) exp_q.push_back(mem[b][i]);
                end
            end
            e_done = failed ? 0 : 1;
        end
        if (e_rt > 255) e_rt = 255;
        e_bytes = exp_q.size();
        expect_bytes = (e_err == 0 && e_bytes > 0);
        pulse_start(a, cnt);
        for (int k = 0; k < 20000; k++) begin
            @(negedge clock);
            start = (k == restart_k);
            if (k == restart_k) block_addr = ~a;
            if (!busy && k != restart_k) begin
                idle_cyc = cyc;
                gone = 1'b1;
                break;
            end
        end
        start = 1'b0;
        check("run_finished", gone, 1);
        repeat (3) @(negedge clock);
        check("done_count", done_cnt, e_done);
        check("error", error, e_err);
        check("retry_total", retry_total, e_rt);
        check("init_start_count", init_cnt, e_init);
        check("rd_start_count", rd_cnt, e_rd);
        check("bytes_out", out_cnt, e_bytes);
        check("bytes_left", exp_q.size(), 0);
        check("busy_idle", busy, 0);
        if (e_err == 1) begin
            check("init_timeout_window",
                  (idle_cyc - init_cyc >= TMO) && (idle_cyc - init_cyc <= TMO + 2), 1);
        end
    endtask

    task automatic fill(input int blk, input int mode);
        for (int i = 0; i < BB; i++)
            mem[blk][i] = (mode == 0) ? 8'h00 : (mode == 1) ? 8'hFF : 8'($urandom);
    endtask

    initial begin
        logic [31:0] ra;
        int          rc;
        bit          seen;
        reset       = 1'b1;
        start       = 1'b0;
        block_addr  = '0;
        block_count = '0;
        abort       = 1'b0;
        init_ok     = 1'b1;
        init_delay  = 5;
        gap_pct     = 0;
        bad_kind    = -1;
        for (int b = 0; b < 4; b++) fails[b] = 0;
        repeat (3) @(negedge clock);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_error", error, 0);
        check("rst_retry_total", retry_total, 0);
        check("rst_init_start", init_start, 0);
        check("rst_rd_start", rd_start, 0);
        check("rst_rd_addr", rd_addr, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        reset = 1'b0;

        fill(0, 1);
        check("model_crc_ff", ref_crc(0), 16'h7FA1);
        fill(0, 0);
        check("model_crc_00", ref_crc(0), 16'h0000);

        // Single zero block at 0x10.
        ready_pct = 100;
        run(32'h10, 1, -1);
        check("t1_retry_total", retry_total, 0);

        // Three 0xFF blocks, byte addressing; ignored start mid-run.
        for (int b = 0; b < 3; b++) fill(b, 1);
        run(32'h0, 3, 700);
        check("t2_init_once", init_cnt, 1);

        // One zero-CRC read then a good read.
        fails[0] = 1;
        bad_kind = 4;
        run(32'h200, 1, -1);
        check("t3_retry_total", retry_total, 1);
        check("t3_rd_starts", rd_cnt, 2);

        // Every read bad: retries exhausted.
        fails[0] = 4;
        bad_kind = 0;
        run(32'h400, 1, -1);
        check("t4_rd_starts", rd_cnt, 4);
        check("t4_error", error, 2);
        fails[0] = 0;

        // Initializer never ready.
        init_ok = 1'b0;
        run(32'h800, 2, -1);
        check("t5_error", error, 1);
        init_ok = 1'b1;

        // Backpressure on random data.
        ready_pct = 50;
        fill(0, 2);
        fill(1, 2);
        run(32'h1000, 2, -1);

        // Reset in the middle of the second capture of block 0.
        fails[0] = 1;
        bad_kind = 0;
        setup(32'h1234, 2);
        expect_bytes = 1'b0;
        pulse_start(32'h1234, 2);
        seen = 1'b0;
        for (int k = 0; k < 3000; k++) begin
            @(negedge clock);
            if (rd_cnt == 2) begin
                seen = 1'b1;
                break;
            end
        end
        check("rst_test_second_read", seen, 1);
        repeat (40) @(posedge clock);
        check("pre_reset_retry", retry_total, 1);
        #2;
        abort = 1'b1;
        reset = 1'b1;
        #1;
        check("mid_busy", busy, 0);
        check("mid_done", done, 0);
        check("mid_error", error, 0);
        check("mid_retry_total", retry_total, 0);
        check("mid_init_start", init_start, 0);
        check("mid_rd_start", rd_start, 0);
        check("mid_rd_addr", rd_addr, 0);
        check("mid_out_valid", out_valid, 0);
        check("mid_out_data", out_data, 0);
        repeat (3) @(negedge clock);
        reset = 1'b0;
        abort = 1'b0;
        fails[0] = 0;
        exp_q = {};
        run(32'hABC0, 1, -1);
        run(32'h5555, 0, -1);
        check("t6_no_init", init_cnt, 0);

        // Randomized runs, including address wrap.
        for (int r = 0; r < 5; r++) begin
            ra = ($urandom_range(0, 2) == 0) ? 32'hFFFF_FE00 : 32'($urandom);
            rc = int'($urandom_range(0, 2));
            for (int b = 0; b < 4; b++) begin
                fill(b, 2);
                fails[b] = ($urandom_range(0, 9) < 6) ? 0 : int'($urandom_range(1, 4));
            end
            bad_kind   = -1;
            gap_pct    = int'($urandom_range(0, 10));
            ready_pct  = int'($urandom_range(40, 100));
            init_delay = int'($urandom_range(0, 20));
            run(ra, rc, -1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sd_block_streamer.md
# sd_block_streamer

Sequencer that reads `block_count` consecutive SD blocks via the existing SPI card initializer and block reader, buffers each block, and verifies its CRC16. Each block is retried up to `MAX_RETRY` times. Only verified bytes are released on a valid/ready byte stream toward the FIFO/UART path. It replaces the hard-wired single-block top-level sequencer and adds multi-block reads, addressing mode, CRC checking, retries, and an init timeout.

## Interface
Parameters:
- `BLOCK_BYTES`, 512, data bytes per block; the reader then sends 2 CRC bytes, MSB first.
- `ADDR_WIDTH`, 32, card address width.
- `COUNT_WIDTH`, 8, width of `block_count`.
- `MAX_RETRY`, 3, re-reads allowed per block after a CRC or length failure.
- `ADDR_MODE`, 0, address step per block: 0 = +1 (block-addressed card), 1 = +`BLOCK_BYTES` (byte-addressed card).
- `INIT_TIMEOUT`, 1_000_000, clock cycles allowed from `init_start` to `init_ready`.

Ports:
- `clock`  in  1  single clock; all logic on the rising edge.
- `reset`  in  1  asynchronous, active-high.
- `start`  in  1  one-cycle request; ignored while `busy`.
- `block_addr`  in  ADDR_WIDTH  first block address; sampled on `start`.
- `block_count`  in  COUNT_WIDTH  number of blocks; sampled on `start`.
- `init_start`  out  1  one-cycle pulse to the card initializer.
- `init_ready`  in  1  initializer done (level).
- `rd_start`  out  1  one-cycle pulse to the block reader.
- `rd_addr`  out  ADDR_WIDTH  address for the current read; stable while the reader is busy.
- `rd_busy`  in  1  reader active.
- `rd_valid`  in  1  one byte on `rd_data` this cycle.
- `rd_data`  in  8  reader byte.
- `out_data`  out  8  verified byte.
- `out_valid`  out  1  `out_data` valid.
- `out_ready`  in  1  sink accepts the byte.
- `busy`  out  1  high in any state except IDLE.
- `done`  out  1  one-cycle pulse on successful completion.
- `error`  out  2  0 none, 1 init timeout, 2 retries exhausted; held until the next accepted `start`.
- `retry_total`  out  8  saturating count of retries in the current run.

## Operation
- Reset values: all outputs 0; state IDLE.
- IDLE: on `start`, latch address and count, clear `error` and `retry_total`.
  - If count = 0, pulse `done` on the next cycle and stay in IDLE.
  - Otherwise go to INIT.
- INIT: pulse `init_start`, then go to WAIT_INIT.
- WAIT_INIT: on `init_ready`, go to READ. If the timeout counter reaches `INIT_TIMEOUT`, set `error`=1 and go to IDLE.
- READ: pulse `rd_start` with `rd_addr` = current address, clear the byte counter and CRC, then go to CAPTURE.
- CAPTURE: on each `rd_valid`:
  - Bytes 0..`BLOCK_BYTES`-1 are written to the block buffer and fed to CRC16-CCITT (poly 0x1021, init 0x0000, MSB-first).
  - The next 2 bytes form the received CRC.
  - Bytes beyond `BLOCK_BYTES`+2 are discarded and mark the block as bad.
  - The falling edge of `rd_busy` moves to CHECK.
- CHECK: pass requires byte count = `BLOCK_BYTES`+2 and computed CRC = received CRC.
  - Pass: go to STREAM.
  - Fail with retries used < `MAX_RETRY`: increment both counters and go to READ, same address.
  - Fail otherwise: set `error`=2 and go to IDLE. No bytes of a failed block are ever emitted.
- STREAM: emit buffer bytes 0..`BLOCK_BYTES`-1 in order.
  - After the last byte is accepted, advance the address by the `ADDR_MODE` step, decrement the remaining count, and reset the per-block retry counter.
  - If the remaining count reaches 0, pulse `done` and go to IDLE. Otherwise go to READ; the card is not re-initialized.
- `rd_valid` outside CAPTURE is ignored.

## Timing
- `init_start` and `rd_start` are exactly one cycle wide, asserted in the cycle after entering INIT/READ.
- Buffer RAM has a 1-cycle read latency. The first `out_valid` rises 2 cycles after entering STREAM.
- Once `out_valid` is high, `out_data` stays stable until `out_ready` is sampled high.
- Throughput is 1 byte/cycle while `out_ready` is held high.
- `done` rises in the cycle after the final handshake; `busy` falls in the same cycle.
- CAPTURE accepts `rd_valid` on consecutive cycles with no stall.
- Address wraps modulo 2^ADDR_WIDTH.
- `retry_total` saturates at 255.
- Asserting `reset` mid-operation immediately returns the block to the reset values. A partial block is discarded.

## Structure
- Shared package holds:
  - state encoding (IDLE, INIT, WAIT_INIT, READ, CAPTURE, CHECK, STREAM);
  - error codes;
  - CRC polynomial/init constants;
  - a byte-wise CRC16 update function.
- One sub-module: `crc16_ccitt_byte` (clock, reset, clear, en, data[7:0], crc[15:0]).
- The buffer is a `BLOCK_BYTES`×8 single-clock RAM, built on the existing dual-port RAM.

## Test plan
- Address 0x10, count 1, ADDR_MODE 0, 512 bytes of 0x00 + CRC 0x0000, `out_ready` held high → 512 bytes of 0x00 emitted, `rd_addr`=0x10, `done` pulse, `error`=0, `retry_total`=0.
- Count 3, ADDR_MODE 1, address 0, each block 512 bytes of 0xFF + CRC 0x7FA1 → `rd_addr` = 0, 512, 1024, with exactly one `init_start`, 1536 bytes out, then `done`.
- First read sends CRC 0x0000 for an all-0xFF block, second read is correct → two `rd_start` pulses at the same address, `retry_total`=1, only 512 bytes out.
- Every read has a bad CRC, MAX_RETRY 3 → 4 `rd_start` pulses, `error`=2, no `out_valid`, `busy` low.
- `init_ready` never asserts, INIT_TIMEOUT 100 → `error`=1 after 100 cycles. Then, while `out_ready` toggles randomly during STREAM, `out_data` stays stable under backpressure and byte order matches the buffer.
- Reset asserted mid-CAPTURE → all outputs 0 immediately. A new `start` proceeds normally and count 0 gives a `done` pulse with no `init_start`.
